// File: rtl/ram_pair_scanner.sv
// Single sweep over two 512x8 RAMs: per-RAM sums, equal-word count and max |RAM0-RAM1|.
// Drives only the shared read address; RAM data arrives one cycle after the address.
module ram_pair_scanner #(
   parameter int DEPTH      = 512,
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLOCK_50_I,
   input  logic                  resetn,
   input  logic                  start_i,
   input  logic [DATA_WIDTH-1:0] read_data0_i,
   input  logic [DATA_WIDTH-1:0] read_data1_i,
   output logic [ADDR_WIDTH-1:0] address_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [16:0]           sum0_o,
   output logic [16:0]           sum1_o,
   output logic [9:0]            equal_count_o,
   output logic [DATA_WIDTH-1:0] max_abs_diff_o
);

   localparam int SUM_W = 17;
   localparam int CNT_W = 10;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FILL,
      S_SCAN,
      S_LAST
   } state_t;

   state_t                  state, state_n;
   logic [ADDR_WIDTH-1:0]   address_n;
   logic                    busy_n;
   logic                    done_n;
   logic                    acc_clr;
   logic                    acc_en;

   logic                    words_eq;
   logic [DATA_WIDTH-1:0]   abs_diff;

   always_comb begin
      state_n   = state;
      address_n = address_o;
      busy_n    = busy_o;
      done_n    = 1'b0;
      acc_clr   = 1'b0;
      acc_en    = 1'b0;
      case (state)
         S_IDLE: begin
            address_n = '0;
            if (start_i) begin
               acc_clr = 1'b1;
               busy_n  = 1'b1;
               state_n = S_FILL;
            end
         end
         // RAM latches address 0 here; nothing valid on q yet
         S_FILL: begin
            address_n = ADDR_WIDTH'(1);
            state_n   = S_SCAN;
         end
         // q holds the word for address_o-1
         S_SCAN: begin
            acc_en = 1'b1;
            if (address_o == LAST_ADDR) begin
               state_n = S_LAST;
            end else begin
               address_n = address_o + ADDR_WIDTH'(1);
            end
         end
         S_LAST: begin
            acc_en    = 1'b1;
            done_n    = 1'b1;
            busy_n    = 1'b0;
            address_n = '0;
            state_n   = S_IDLE;
         end
         default: begin
            state_n   = S_IDLE;
            address_n = '0;
            busy_n    = 1'b0;
         end
      endcase
   end

   always_comb begin
      words_eq = (read_data0_i == read_data1_i);
      abs_diff = (read_data0_i >= read_data1_i) ? (read_data0_i - read_data1_i)
                                                : (read_data1_i - read_data0_i);
   end

   always_ff @(posedge CLOCK_50_I) begin
      if (!resetn) begin
         state          <= S_IDLE;
         address_o      <= '0;
         busy_o         <= 1'b0;
         done_o         <= 1'b0;
         sum0_o         <= '0;
         sum1_o         <= '0;
         equal_count_o  <= '0;
         max_abs_diff_o <= '0;
      end else begin
         state     <= state_n;
         address_o <= address_n;
         busy_o    <= busy_n;
         done_o    <= done_n;
         if (acc_clr) begin
            sum0_o         <= '0;
            sum1_o         <= '0;
            equal_count_o  <= '0;
            max_abs_diff_o <= '0;
         end else if (acc_en) begin
            sum0_o <= sum0_o + SUM_W'(read_data0_i);
            sum1_o <= sum1_o + SUM_W'(read_data1_i);
            if (words_eq)
               equal_count_o <= equal_count_o + CNT_W'(1);
            if (abs_diff > max_abs_diff_o)
               max_abs_diff_o <= abs_diff;
         end
      end
   end

endmodule

// File: doc/ram_pair_scanner.md
Name: ram_pair_scanner

Overview:
Read-only post-processing stage that sits downstream of the dual-RAM add/subtract pass. On a start pulse it sweeps every address of the two 512x8 single-port RAMs once and accumulates per-RAM sums, the count of equal words, and the maximum absolute difference. It then pulses done with stable results. It drives the shared RAM address bus only. Write enables stay with the upstream stage, and the top level muxes the address bus by busy_o.

Parameters:
DEPTH, 512, number of words scanned per RAM (address 0..DEPTH-1)
ADDR_WIDTH, 9, RAM address width; must satisfy 2^ADDR_WIDTH >= DEPTH
DATA_WIDTH, 8, RAM word width

Ports:
CLOCK_50_I  input  1  system clock, all logic on rising edge
resetn  input  1  synchronous active-low reset, sampled on rising edge of CLOCK_50_I
start_i  input  1  begin a scan; sampled only in S_IDLE
read_data0_i  input  DATA_WIDTH  q of RAM0; valid one cycle after address presented
read_data1_i  input  DATA_WIDTH  q of RAM1; same timing
address_o  output  ADDR_WIDTH  registered read address to both RAMs
busy_o  output  1  high from the cycle after start is accepted until done
done_o  output  1  one-cycle pulse; results final while high
sum0_o  output  17  sum of all RAM0 words, unsigned
sum1_o  output  17  sum of all RAM1 words, unsigned
equal_count_o  output  10  number of addresses with RAM0 word == RAM1 word
max_abs_diff_o  output  DATA_WIDTH  max over addresses of |RAM0 - RAM1|

Behaviour:
- Reset (resetn low at an edge): state S_IDLE; address_o=0; busy_o=0; done_o=0; sum0_o=0; sum1_o=0; equal_count_o=0; max_abs_diff_o=0. Reset has priority over everything.
- States:
  - S_IDLE, S_FILL, S_SCAN, S_LAST. All outputs are registered.
- S_IDLE:
  - address_o held 0; done_o<=0.
  - If start_i=1: clear all four accumulators, busy_o<=1, state<=S_FILL.
- S_FILL:
  - Address 0 is on the bus, and the RAM captures it at this edge.
  - address_o<=1; state<=S_SCAN. No accumulation.
- S_SCAN:
  - Data on read_data*_i belongs to address_o-1. Accumulate it.
  - If address_o==DEPTH-1: hold address_o, state<=S_LAST.
  - Otherwise: address_o<=address_o+1.
- S_LAST:
  - Accumulate the word for address DEPTH-1.
  - done_o<=1, busy_o<=0, address_o<=0, state<=S_IDLE.
- Accumulate step, all widths zero-extended:
  - sum0 += d0; sum1 += d1.
  - If d0==d1: equal_count += 1.
  - d = (d0>=d1) ? d0-d1 : d1-d0. If d > max: max <= d.
- Width rules:
  - Maximum sum is 512*255 = 130560, which fits in 17 bits, so no saturation logic is needed.
  - equal_count maximum is 512, which fits in 10 bits.
- Latency: done_o is high in the cycle after the DEPTH+1-th rising edge following the edge that sampled start_i (513 edges for the default DEPTH). Each address is read exactly once, in ascending order.
- Results hold their values after done_o until the next accepted start, which clears them at the accepting edge.
- start_i while busy (S_FILL, S_SCAN, S_LAST) is ignored and causes no restart. start_i held high continuously causes back-to-back scans: a new scan is accepted in the cycle done_o is high, because the state is then S_IDLE.
- Reset mid-scan: aborts immediately with all reset values. No done_o pulse. Partial sums are discarded.
- read_data inputs are ignored in S_IDLE and S_FILL.

Test Plan:
1. Bench RAM models have 1-cycle read latency. Both RAMs all 0x00, start pulse -> done_o after 513 edges; sum0=0, sum1=0, equal_count=512, max_abs_diff=0; busy_o high 513 cycles.
2. RAM0[i]=i[7:0], RAM1 all 0x00 -> sum0=65280, sum1=0, equal_count=2 (addresses 0 and 256), max_abs_diff=255. Address trace is 0,1,...,511 with no repeats or skips.
3. Both RAMs all 0xFF -> sum0=sum1=130560 (no wrap), equal_count=512, max_abs_diff=0. Then RAM1[300]=0x00 and RAM0[300]=0xFF, rescan -> sum1=130305, equal_count=511, max_abs_diff=255.
4. start_i re-pulsed at scan cycles 10 and 400 -> single done_o at edge 513; results identical to an undisturbed scan. start_i held high -> done_o pulses every 514 cycles.
5. Reset asserted while address_o=200 -> next cycle all outputs 0, busy_o=0, no done_o. Fresh start then gives full correct results, as in case 2.
6. RAM0[i]=0x80, RAM1[i]=i[7:0] -> sum0=65536, sum1=65280, equal_count=2, max_abs_diff=128 (from i[7:0]=0).
